seg7_scan_mux: RTL and testbench

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

---
 rtl/seg7_scan_mux.sv | 135 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for six common-anode 7-segment digits.
// Each frame walks digits 0..5; every digit gets a dark BLANK gap followed by a
// lit SHOW window. Digit patterns and blink mask are snapshotted at frame start
// so the picture never tears mid-frame. Selected digits can blink at a rate of
// BLINK_FRAMES frames per phase.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   enable       scan enable; low blanks the display and restarts the scan
//   hex0..hex5   active-low segment patterns, one per digit
//   blink_mask   bit i set -> digit i blinks
//   seg_n        registered active-low segment bus
//   dig_n        registered one-hot active-low digit select
//   frame_start  registered one-cycle pulse on the first BLANK cycle of a frame
module seg7_scan_mux #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  input  logic [6:0] hex4,
  input  logic [6:0] hex5,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg_n,
  output logic [5:0] dig_n,
  output logic       frame_start
);

  localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FR_LAST    = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [CW-1:0]     cnt;
  logic [FW-1:0]     fcnt;
  logic              blink_phase;
  logic [5:0][6:0]   sh_hex;
  logic [5:0]        sh_mask;
  logic [5:0][6:0]   hex_in;

  assign hex_in = {hex5, hex4, hex3, hex2, hex1, hex0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      sh_hex      <= {6{7'h7F}};
      sh_mask     <= '0;
      seg_n       <= 7'h7F;
      dig_n       <= 6'h3F;
      frame_start <= 1'b0;
    end else if (!enable) begin
      // Disable wins over everything, including a pending frame start;
      // shadows are kept so nothing stale-but-valid is lost.
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      seg_n       <= 7'h7F;
      dig_n       <= 6'h3F;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          // First frame after idle: capture, pulse, but do not count it
          // toward the blink frame counter.
          state       <= BLANK;
          idx         <= '0;
          cnt         <= '0;
          sh_hex      <= hex_in;
          sh_mask     <= blink_mask;
          frame_start <= 1'b1;
          seg_n       <= 7'h7F;
          dig_n       <= 6'h3F;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            dig_n <= ~(6'b1 << idx);
            seg_n <= (sh_mask[idx] && blink_phase) ? 7'h7F : sh_hex[idx];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            seg_n <= 7'h7F;
            dig_n <= 6'h3F;
            if (idx == 3'd5) begin
              // Wrap is a frame start: new snapshot and blink bookkeeping.
              idx         <= '0;
              sh_hex      <= hex_in;
              sh_mask     <= blink_mask;
              frame_start <= 1'b1;
              if (fcnt == FR_LAST) begin
                fcnt        <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                fcnt <= fcnt + 1'b1;
              end
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (normal timing and the 1/1 corner)
// share stimulus. A frame-position reference model (time since scan start,
// split into frame / digit / blank-or-show by division) checks every cycle;
// a vector table and short directed sequences cover the named scenarios.
module tb_seg7_scan_mux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] hx [6];
  logic [5:0] msk;
  logic [6:0] seg_o [2];
  logic [5:0] dig_o [2];
  logic       fs_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.CLK_DIV(4), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut0 (
    .clk(clk), .reset_n(rst_n), .enable(en),
    .hex0(hx[0]), .hex1(hx[1]), .hex2(hx[2]), .hex3(hx[3]), .hex4(hx[4]), .hex5(hx[5]),
    .blink_mask(msk), .seg_n(seg_o[0]), .dig_n(dig_o[0]), .frame_start(fs_o[0]));

  seg7_scan_mux #(.CLK_DIV(1), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut1 (
    .clk(clk), .reset_n(rst_n), .enable(en),
    .hex0(hx[0]), .hex1(hx[1]), .hex2(hx[2]), .hex3(hx[3]), .hex4(hx[4]), .hex5(hx[5]),
    .blink_mask(msk), .seg_n(seg_o[1]), .dig_n(dig_o[1]), .frame_start(fs_o[1]));

  // Reference model state, per instance.
  bit         run [2];
  int         t   [2];
  logic [6:0] mh  [2][6];
  logic [5:0] mm  [2];

  function automatic int blnk(int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int slot(int k); return (k == 0) ? 6 : 2; endfunction
  function automatic int per(int k);  return 6 * slot(k); endfunction

  task automatic capture(input int k);
    for (int d = 0; d < 6; d++) mh[k][d] = hx[d];
    mm[k] = msk;
  endtask

  // Called right after a rising edge, before inputs change: sees edge values.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        run[k] = 1'b0; t[k] = 0; mm[k] = '0;
        for (int d = 0; d < 6; d++) mh[k][d] = 7'h7F;
      end else if (!en) begin
        run[k] = 1'b0; t[k] = 0;
      end else if (!run[k]) begin
        run[k] = 1'b1; t[k] = 0; capture(k);
      end else begin
        t[k]++;
        if (t[k] % per(k) == 0) capture(k);
      end
    end
  endtask

  task automatic exp_out(input int k, output logic [13:0] e);
    int p, f, d, w;
    bit ph;
    if (!run[k]) begin
      e = {7'h7F, 6'h3F, 1'b0};
    end else begin
      p  = t[k] % per(k);
      f  = t[k] / per(k);
      d  = p / slot(k);
      w  = p % slot(k);
      ph = ((f / 2) % 2) == 1;
      if (w < blnk(k)) e = {7'h7F, 6'h3F, p == 0};
      else e = {(mm[k][d] && ph) ? 7'h7F : mh[k][d], 6'h3F & ~(6'd1 << d), 1'b0};
    end
  endtask

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got seg=%h dig=%h fs=%b, want seg=%h dig=%h fs=%b",
               nm, act[13:7], act[6:1], act[0], want[13:7], want[6:1], want[0]);
    end
  endtask

  function automatic logic [13:0] outs(int k);
    return {seg_o[k], dig_o[k], fs_o[k]};
  endfunction

  task automatic cyc();
    logic [13:0] e;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_out(k, e);
      chk($sformatf("model dut%0d t=%0d", k, t[k]), outs(k), e);
    end
  endtask

  typedef struct {
    int         t;
    bit         upd;   // after this cycle, set hex0 to 7'h00
    logic [6:0] seg;
    logic [5:0] dig;
    logic       fs;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit found;
    tbl[0]  = '{0,  1'b0, 7'h7F, 6'h3F, 1'b1};
    tbl[1]  = '{1,  1'b0, 7'h7F, 6'h3F, 1'b0};
    tbl[2]  = '{2,  1'b0, 7'h40, 6'h3E, 1'b0};
    tbl[3]  = '{5,  1'b0, 7'h40, 6'h3E, 1'b0};
    tbl[4]  = '{6,  1'b0, 7'h7F, 6'h3F, 1'b0};
    tbl[5]  = '{8,  1'b0, 7'h79, 6'h3D, 1'b0};
    tbl[6]  = '{14, 1'b0, 7'h24, 6'h3B, 1'b0};
    tbl[7]  = '{20, 1'b1, 7'h30, 6'h37, 1'b0};
    tbl[8]  = '{26, 1'b0, 7'h19, 6'h2F, 1'b0};
    tbl[9]  = '{32, 1'b0, 7'h12, 6'h1F, 1'b0};
    tbl[10] = '{35, 1'b0, 7'h12, 6'h1F, 1'b0};
    tbl[11] = '{36, 1'b0, 7'h7F, 6'h3F, 1'b1};
    tbl[12] = '{38, 1'b0, 7'h00, 6'h3E, 1'b0};
    tbl[13] = '{44, 1'b0, 7'h79, 6'h3D, 1'b0};

    hx[0] = 7'h40; hx[1] = 7'h79; hx[2] = 7'h24;
    hx[3] = 7'h30; hx[4] = 7'h19; hx[5] = 7'h12;
    msk = '0;

    // Reset and idle.
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Basic scan plus mid-frame hex0 update.
    en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      cyc();
      for (int i = 0; i < 14; i++) begin
        if (tbl[i].t == c) begin
          chk($sformatf("scan t=%0d", c), outs(0), {tbl[i].seg, tbl[i].dig, tbl[i].fs});
          if (tbl[i].upd) hx[0] = 7'h00;
        end
      end
    end

    // Blink on digit 1, starting from a fresh scan.
    msk = 6'b000010;
    en = 1'b0;
    cyc();
    en = 1'b1;
    for (int c = 0; c <= 220; c++) begin
      cyc();
      case (c)
        8, 44, 152: chk($sformatf("blink on c=%0d", c), outs(0), {7'h79, 6'h3D, 1'b0});
        80, 116:    chk($sformatf("blink off c=%0d", c), outs(0), {7'h7F, 6'h3D, 1'b0});
        74:         chk("blink other digit", outs(0), {7'h00, 6'h3E, 1'b0});
        default: ;
      endcase
    end

    // Enable drop during SHOW of digit 2.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (dig_o[0] == 6'h3B) found = 1'b1;
    end
    chk("wait idx2 show", 14'(found), 14'd1);
    en = 1'b0;
    cyc();
    chk("drop off", outs(0), {7'h7F, 6'h3F, 1'b0});
    en = 1'b1;
    cyc();
    chk("reenable start", outs(0), {7'h7F, 6'h3F, 1'b1});
    repeat (2) cyc();
    chk("reenable digit0", outs(0), {7'h00, 6'h3E, 1'b0});
    repeat (6) cyc();
    chk("reenable phase0", outs(0), {7'h79, 6'h3D, 1'b0});

    // Asynchronous reset in the middle of a SHOW window.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (dig_o[0] != 6'h3F) found = 1'b1;
    end
    chk("wait show", 14'(found), 14'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst dut0", outs(0), {7'h7F, 6'h3F, 1'b0});
    chk("async rst dut1", outs(1), {7'h7F, 6'h3F, 1'b0});
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("post rst frame", outs(0), {7'h7F, 6'h3F, 1'b1});

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(399) != 0);
      rst_n = ($urandom_range(1499) != 0);
      if ($urandom_range(9) == 0) begin
        int j;
        j = $urandom_range(5);
        hx[j] = 7'($urandom);
      end
      if ($urandom_range(149) == 0) msk = 6'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
